asg_seq_ctrl: RTL
=================

Name: asg_seq_ctrl

Overview:
- Segment sequencer for one ASG channel (red_pitaya_asg_ch).
- Holds a small table of waveform segments, each defined by offset, size, step, cycle count and gap.
- Reprograms the channel's configuration inputs, resets it, software-triggers it and counts table passes, so that several sub-waveforms of one buffer play back to back without CPU intervention.
- Sits between the ASG register bank and the channel instance.

Parameters:
RSZ, 14, channel buffer address width; pointer fields are RSZ+16 bits
NSEG, 8, segment table depth (power of two)
SW, 3, log2(NSEG)

Ports:
dac_clk_i  in  1  DAC clock
dac_rst_i  in  1  synchronous reset, active high
tbl_we_i  in  1  table write strobe
tbl_addr_i  in  SW  segment index
tbl_fld_i  in  2  field select: 0 ofs, 1 size, 2 step, 3 {gap[31:16], ncyc[15:0]}
tbl_wdata_i  in  32  write data; fields 0-2 use [RSZ+15:0]
start_i  in  1  start sequence (pulse)
stop_i  in  1  abort sequence (pulse)
loop_i  in  1  restart at segment 0 after the last segment
seq_len_i  in  SW+1  number of segments, 1..NSEG
chan_wrap_i  in  1  channel trig_done_o
set_ofs_o  out  RSZ+16  to channel set_ofs_i
set_size_o  out  RSZ+16  to channel set_size_i
set_step_o  out  RSZ+16  to channel set_step_i
set_rst_o  out  1  to channel set_rst_i
trig_sw_o  out  1  to channel trig_sw_i; channel trig_src is fixed at 1
busy_o  out  1  sequence active
seg_idx_o  out  SW  current segment
seq_done_o  out  1  one-cycle pulse at sequence end

Behaviour:
- Reset values: all set_* data outputs 0; set_rst_o=1; trig_sw_o=0; busy_o=0; seg_idx_o=0; seq_done_o=0; FSM in IDLE. Table contents are not reset.
- Table: synchronous write; read has 1-cycle latency. A write to a segment that is not currently loaded takes effect when that segment is next loaded. The loaded segment's registered copy is unaffected by writes.
- FSM states:
  - IDLE: set_rst_o=1. On start_i with 1<=seq_len_i<=NSEG: latch seq_len, seg=0, go to LOAD. start_i with seq_len_i=0 or >NSEG is ignored.
  - LOAD (2 cycles): issue table read, then register ofs/size/step/ncyc/gap onto outputs and internal counters. Go to ARM.
  - ARM (1 cycle): set_rst_o=1 with the new configuration stable. Go to TRIG.
  - TRIG (1 cycle): set_rst_o=0, trig_sw_o=1. Clear pass_cnt, load a 3-cycle blanking counter. Go to RUN.
  - RUN: set_rst_o=0.
    - chan_wrap_i is ignored while blanking is nonzero; this masks the trig_in alias of trig_done.
    - Each unmasked chan_wrap_i increments pass_cnt.
    - When pass_cnt reaches ncyc: if gap=0 go to NEXT, else go to GAP.
    - ncyc=0 means run until stop_i.
  - GAP: set_rst_o=1, which parks the channel at its offset. Count gap dac_clk cycles, then go to NEXT.
  - NEXT (1 cycle):
    - If seg+1 < seq_len: seg++, go to LOAD.
    - Else if loop_i (sampled here): seg=0, go to LOAD.
    - Else: pulse seq_done_o, go to IDLE.
- busy_o=1 in every state except IDLE. seg_idx_o = seg.
- stop_i in any non-IDLE state: next cycle goes to IDLE, set_rst_o=1, no seq_done_o. stop_i wins over a coincident start_i. start_i while busy is ignored.
- Minimum inter-segment dead time is 5 cycles with gap=0: NEXT, LOAD×2, ARM, TRIG.
- gap counter is 16 bits; pass_cnt is 16 bits and compared for equality.
- dac_rst_i mid-operation: immediately returns all outputs to reset values on the next edge.

Optional Feature:
Macro ASG_SEQ_DBLBUF_EN.
- Defined: the table is two banks. Writes go to the shadow bank, and LOAD reads the active bank. Banks swap only in IDLE and at NEXT when wrapping to segment 0, so a looping sequence picks up a complete new table atomically.
- Undefined: single bank with the immediate-write behaviour described above.

Decomposition:
- Package asg_seq_pkg: FSM state enum (IDLE, LOAD, ARM, TRIG, RUN, GAP, NEXT), field codes FLD_OFS/FLD_SIZE/FLD_STEP/FLD_CYC, blanking constant 3, pointer width function RSZ+16.
- Sub-module asg_seq_tbl: one-write/one-read RAM holding the four fields per segment, with optional double bank.

Test Plan:
- 1: seg0 {ofs=0, size=0x3FF0000, step=0x10000, ncyc=2, gap=0}, seq_len=1, start -> set_rst_o falls and trig_sw_o pulses 4 cycles after start; after 2 chan_wrap pulses NEXT then seq_done_o pulse; busy_o low; set_rst_o=1.
- 2: two segments, seg1 gap=100, loop_i=0 -> after seg0 completes, 5 cycles later trig_sw_o for seg1 with set_ofs_o = seg1.ofs; after seg1 completes, set_rst_o high for exactly 100 cycles, then seq_done_o.
- 3: chan_wrap_i asserted in the TRIG cycle and RUN cycles 1-2 -> not counted; a pulse on cycle 3 is counted.
- 4: ncyc=0 run, stop_i after 1000 cycles -> IDLE next cycle, set_rst_o=1, seq_done_o stays 0; start_i+stop_i in the same cycle from IDLE -> stays IDLE.
- 5: loop_i=1 with 3 segments -> seg_idx_o sequence 0,1,2,0,1; rewrite seg1 ofs during seg2 -> second pass of seg1 uses the new ofs (ASG_SEQ_DBLBUF_EN defined: old ofs until the bank swap at wrap).
- 6: dac_rst_i in RUN -> next edge: busy_o=0, set_rst_o=1, trig_sw_o=0, seg_idx_o=0; seq_len_i=0 with start -> ignored.

Source files
------------

// File: rtl/asg_seq_pkg.sv
// asg_seq_pkg: shared types and constants for the ASG segment sequencer.
// Optional feature macro: ASG_SEQ_DBLBUF_EN (double-banked segment table).
package asg_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ARM,
    TRIG,
    RUN,
    GAP,
    NEXT
  } state_e;

  localparam logic [1:0] FLD_OFS  = 2'd0;
  localparam logic [1:0] FLD_SIZE = 2'd1;
  localparam logic [1:0] FLD_STEP = 2'd2;
  localparam logic [1:0] FLD_CYC  = 2'd3;

  localparam int BLANK_CYC = 3;

  function automatic int ptr_w(input int rsz);
    return rsz + 16;
  endfunction

endpackage

// File: rtl/asg_seq_tbl.sv
// asg_seq_tbl: segment table, one write port, one registered read port.
// ASG_SEQ_DBLBUF_EN: writes hit the shadow bank, reads the active bank.
module asg_seq_tbl
  import asg_seq_pkg::*;
#(
  parameter int PW   = 30,
  parameter int NSEG = 8,
  parameter int SW   = 3
) (
  input  logic          clk_i,
`ifdef ASG_SEQ_DBLBUF_EN
  input  logic          rst_i,
  input  logic          swap_i,
`endif
  input  logic          we_i,
  input  logic [SW-1:0] waddr_i,
  input  logic [1:0]    fld_i,
  input  logic [31:0]   wdata_i,
  input  logic [SW-1:0] raddr_i,
  output logic [PW-1:0] ofs_o,
  output logic [PW-1:0] size_o,
  output logic [PW-1:0] step_o,
  output logic [31:0]   cyc_o
);

`ifdef ASG_SEQ_DBLBUF_EN
  localparam int AW = SW + 1;

  logic          bank_q;
  logic          bank_d;
  logic [AW-1:0] wa;
  logic [AW-1:0] ra;

  // active bank flips only when the controller asks for it
  always_comb begin
    bank_d = bank_q ^ swap_i;
  end

  // active bank register
  always_ff @(posedge clk_i) begin
    if (rst_i) bank_q <= 1'b0;
    else       bank_q <= bank_d;
  end

  assign wa = {~bank_q, waddr_i};
  assign ra = { bank_q, raddr_i};
`else
  localparam int AW = SW;

  logic [AW-1:0] wa;
  logic [AW-1:0] ra;

  assign wa = waddr_i;
  assign ra = raddr_i;
`endif

  logic [PW-1:0] ofs_mem  [2**AW];
  logic [PW-1:0] size_mem [2**AW];
  logic [PW-1:0] step_mem [2**AW];
  logic [31:0]   cyc_mem  [2**AW];

  // field write, contents deliberately not reset
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      unique case (fld_i)
        FLD_OFS:  ofs_mem[wa]  <= wdata_i[PW-1:0];
        FLD_SIZE: size_mem[wa] <= wdata_i[PW-1:0];
        FLD_STEP: step_mem[wa] <= wdata_i[PW-1:0];
        FLD_CYC:  cyc_mem[wa]  <= wdata_i;
      endcase
    end
  end

  // registered read, one cycle latency
  always_ff @(posedge clk_i) begin
    ofs_o  <= ofs_mem[ra];
    size_o <= size_mem[ra];
    step_o <= step_mem[ra];
    cyc_o  <= cyc_mem[ra];
  end

endmodule

// File: rtl/asg_seq_ctrl.sv
// asg_seq_ctrl: segment sequencer driving one red_pitaya_asg_ch channel.
// Optional feature macro: ASG_SEQ_DBLBUF_EN (double-banked segment table).
module asg_seq_ctrl
  import asg_seq_pkg::*;
#(
  parameter int RSZ  = 14,
  parameter int NSEG = 8,
  parameter int SW   = 3
) (
  input  logic             dac_clk_i,
  input  logic             dac_rst_i,
  input  logic             tbl_we_i,
  input  logic [SW-1:0]    tbl_addr_i,
  input  logic [1:0]       tbl_fld_i,
  input  logic [31:0]      tbl_wdata_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             loop_i,
  input  logic [SW:0]      seq_len_i,
  input  logic             chan_wrap_i,
  output logic [RSZ+15:0]  set_ofs_o,
  output logic [RSZ+15:0]  set_size_o,
  output logic [RSZ+15:0]  set_step_o,
  output logic             set_rst_o,
  output logic             trig_sw_o,
  output logic             busy_o,
  output logic [SW-1:0]    seg_idx_o,
  output logic             seq_done_o
);

  localparam int PW = ptr_w(RSZ);
  localparam logic [SW:0] NSEG_L = (SW+1)'(NSEG);
  localparam logic [SW:0] ONE_L  = (SW+1)'(1);
  localparam logic [1:0]  BLANK_INIT = 2'(BLANK_CYC - 1);

  state_e        state_q, state_d;
  logic [SW-1:0] seg_q, seg_d;
  logic [SW:0]   len_q, len_d;
  logic          ld_q, ld_d;
  logic [PW-1:0] ofs_q, ofs_d;
  logic [PW-1:0] size_q, size_d;
  logic [PW-1:0] step_q, step_d;
  logic [15:0]   ncyc_q, ncyc_d;
  logic [15:0]   gap_q, gap_d;
  logic [15:0]   pass_q, pass_d;
  logic [1:0]    blank_q, blank_d;
  logic [15:0]   gcnt_q, gcnt_d;
  logic          done;
  logic          len_ok;
  logic [SW:0]   seg_nx;

  logic [PW-1:0] rd_ofs;
  logic [PW-1:0] rd_size;
  logic [PW-1:0] rd_step;
  logic [31:0]   rd_cyc;

`ifdef ASG_SEQ_DBLBUF_EN
  logic swap;
`endif

  assign len_ok = (seq_len_i != '0) && (seq_len_i <= NSEG_L);
  assign seg_nx = {1'b0, seg_q} + ONE_L;

  asg_seq_tbl #(
    .PW   (PW),
    .NSEG (NSEG),
    .SW   (SW)
  ) u_tbl (
    .clk_i   (dac_clk_i),
`ifdef ASG_SEQ_DBLBUF_EN
    .rst_i   (dac_rst_i),
    .swap_i  (swap),
`endif
    .we_i    (tbl_we_i),
    .waddr_i (tbl_addr_i),
    .fld_i   (tbl_fld_i),
    .wdata_i (tbl_wdata_i),
    .raddr_i (seg_q),
    .ofs_o   (rd_ofs),
    .size_o  (rd_size),
    .step_o  (rd_step),
    .cyc_o   (rd_cyc)
  );

  // next-state, segment bookkeeping and pass counting
  always_comb begin
    state_d = state_q;
    seg_d   = seg_q;
    len_d   = len_q;
    ld_d    = 1'b0;
    ofs_d   = ofs_q;
    size_d  = size_q;
    step_d  = step_q;
    ncyc_d  = ncyc_q;
    gap_d   = gap_q;
    pass_d  = pass_q;
    blank_d = blank_q;
    gcnt_d  = gcnt_q;
    done    = 1'b0;
`ifdef ASG_SEQ_DBLBUF_EN
    swap    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (start_i && !stop_i && len_ok) begin
          len_d   = seq_len_i;
          seg_d   = '0;
          state_d = LOAD;
`ifdef ASG_SEQ_DBLBUF_EN
          swap    = 1'b1;
`endif
        end
      end
      LOAD: begin
        if (!ld_q) begin
          ld_d = 1'b1;
        end else begin
          ofs_d   = rd_ofs;
          size_d  = rd_size;
          step_d  = rd_step;
          ncyc_d  = rd_cyc[15:0];
          gap_d   = rd_cyc[31:16];
          state_d = ARM;
        end
      end
      ARM: begin
        state_d = TRIG;
      end
      TRIG: begin
        // the TRIG cycle is the first blanked cycle
        pass_d  = '0;
        blank_d = BLANK_INIT;
        state_d = RUN;
      end
      RUN: begin
        if (blank_q != '0) begin
          blank_d = blank_q - 2'd1;
        end else if (chan_wrap_i) begin
          pass_d = pass_q + 16'd1;
          if (ncyc_q != '0 && pass_d == ncyc_q) begin
            if (gap_q == '0) begin
              state_d = NEXT;
            end else begin
              gcnt_d  = gap_q;
              state_d = GAP;
            end
          end
        end
      end
      GAP: begin
        if (gcnt_q <= 16'd1) state_d = NEXT;
        else                 gcnt_d  = gcnt_q - 16'd1;
      end
      NEXT: begin
        if (seg_nx < len_q) begin
          seg_d   = seg_nx[SW-1:0];
          state_d = LOAD;
        end else if (loop_i) begin
          seg_d   = '0;
          state_d = LOAD;
`ifdef ASG_SEQ_DBLBUF_EN
          swap    = 1'b1;
`endif
        end else begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (stop_i && state_q != IDLE) begin
      state_d = IDLE;
      done    = 1'b0;
`ifdef ASG_SEQ_DBLBUF_EN
      swap    = 1'b0;
`endif
    end
  end

  // state and configuration registers
  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      state_q <= IDLE;
      seg_q   <= '0;
      len_q   <= '0;
      ld_q    <= 1'b0;
      ofs_q   <= '0;
      size_q  <= '0;
      step_q  <= '0;
      ncyc_q  <= '0;
      gap_q   <= '0;
      pass_q  <= '0;
      blank_q <= '0;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      len_q   <= len_d;
      ld_q    <= ld_d;
      ofs_q   <= ofs_d;
      size_q  <= size_d;
      step_q  <= step_d;
      ncyc_q  <= ncyc_d;
      gap_q   <= gap_d;
      pass_q  <= pass_d;
      blank_q <= blank_d;
      gcnt_q  <= gcnt_d;
    end
  end

  assign set_ofs_o  = ofs_q;
  assign set_size_o = size_q;
  assign set_step_o = step_q;
  assign set_rst_o  = !(state_q == TRIG || state_q == RUN);
  assign trig_sw_o  = (state_q == TRIG);
  assign busy_o     = (state_q != IDLE);
  assign seg_idx_o  = seg_q;
  assign seq_done_o = done;

endmodule
